// File: rtl/mdr_fifo_if.sv
// mdr_fifo_if: memory-side and datapath-side handshake bundle for mdr_fifo; MDR_PARITY_EN adds parity signals
interface mdr_fifo_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
);
  localparam int AW = $clog2(DEPTH);
  logic             mem_valid;
  logic             mem_ready;
  logic [WIDTH-1:0] memdatain;
  logic [1:0]       ld_mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] memdataout;
  logic [AW:0]      count;
`ifdef MDR_PARITY_EN
  logic             mem_parity;
  logic             par_err;
  logic             par_err_sticky;
  modport master (output mem_valid, memdatain, ld_mode, out_ready, mem_parity,
                  input mem_ready, out_valid, memdataout, count, par_err, par_err_sticky);
  modport slave (input mem_valid, memdatain, ld_mode, out_ready, mem_parity,
                 output mem_ready, out_valid, memdataout, count, par_err, par_err_sticky);
`else
  modport master (output mem_valid, memdatain, ld_mode, out_ready,
                  input mem_ready, out_valid, memdataout, count);
  modport slave (input mem_valid, memdatain, ld_mode, out_ready,
                 output mem_ready, out_valid, memdataout, count);
`endif
endinterface

// File: rtl/mdr_fifo.sv
// mdr_fifo: DEPTH-entry memory data FIFO with load-width extension at capture; MDR_PARITY_EN adds per-entry parity tracking
module mdr_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int AW = $clog2(DEPTH)
) (
  input logic       clk,
  input logic       rst,
  input logic       flush,
  mdr_fifo_if.slave bus
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      cnt;
  logic [WIDTH-1:0] ext;
  logic             push, pop, clr;
  assign clr = rst || flush;
  assign bus.mem_ready = cnt != (AW+1)'(DEPTH);
  assign bus.out_valid = cnt != '0;
  assign bus.count = cnt;
  assign push = bus.mem_valid && bus.mem_ready;
  assign pop = bus.out_valid && bus.out_ready;
  assign bus.memdataout = bus.out_valid ? mem[rd_ptr] : '0;
  always_comb begin
    ext = bus.ld_mode == 2'b00 ? bus.memdatain :
          bus.ld_mode == 2'b01 ? {{(WIDTH-8){1'b0}}, bus.memdatain[7:0]} :
          bus.ld_mode == 2'b10 ? {{(WIDTH-8){bus.memdatain[7]}}, bus.memdatain[7:0]} :
                                 {{(WIDTH-8){1'b0}}, bus.memdatain[WIDTH-1 -: 8]};
  end
  always_ff @(posedge clk) begin
    if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end
  // storage carries no reset; only pointers and count define what is visible
  always_ff @(posedge clk) begin
    if (!clr && push) mem[wr_ptr] <= ext;
  end
`ifdef MDR_PARITY_EN
  logic perr [DEPTH];
  logic sticky;
  logic err;
  assign err = ^bus.memdatain ^ bus.mem_parity;
  assign bus.par_err = bus.out_valid && perr[rd_ptr];
  assign bus.par_err_sticky = sticky;
  always_ff @(posedge clk) begin
    if (!clr && push) perr[wr_ptr] <= err;
  end
  always_ff @(posedge clk) begin
    if (clr) sticky <= 1'b0;
    else if (push && err) sticky <= 1'b1;
  end
`endif
endmodule

// File: tb/tb_mdr_fifo.sv
// tb_mdr_fifo: directed and randomized checks of mdr_fifo against a queue-based reference model
module tb_mdr_fifo;
  localparam int W = 16;
  localparam int D = 4;
  logic clk = 1'b0;
  logic rst, flush;
  int vectors = 0;
  int miscompares = 0;
  logic [W-1:0] q[$];
  bit eq[$];
  bit sticky_m = 0;
  mdr_fifo_if #(.WIDTH(W), .DEPTH(D)) bus ();
  mdr_fifo #(.WIDTH(W), .DEPTH(D)) dut (.clk(clk), .rst(rst), .flush(flush), .bus(bus));
  always #5 clk = ~clk;
  function automatic logic [W-1:0] ext(logic [W-1:0] d, logic [1:0] m);
    int unsigned lo = int'(d) % 256;
    case (m)
      2'b00: return d;
      2'b01: return W'(lo);
      2'b10: return W'(lo >= 128 ? lo + (2**W - 256) : lo);
      default: return W'(int'(d) / (2**(W-8)));
    endcase
  endfunction
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic cyc();
    bit push, pop, perr, c;
    logic [W-1:0] e;
    chk("count", 32'(bus.count), 32'(q.size()));
    chk("mem_ready", 32'(bus.mem_ready), 32'(q.size() != D));
    chk("out_valid", 32'(bus.out_valid), 32'(q.size() != 0));
    chk("memdataout", 32'(bus.memdataout), q.size() != 0 ? 32'(q[0]) : 32'd0);
`ifdef MDR_PARITY_EN
    chk("par_err", 32'(bus.par_err), q.size() != 0 ? 32'(eq[0]) : 32'd0);
    chk("par_err_sticky", 32'(bus.par_err_sticky), 32'(sticky_m));
    perr = ($countones(bus.memdatain) % 2 == 1) != bus.mem_parity;
`else
    perr = 0;
`endif
    push = bus.mem_valid && q.size() < D;
    pop = bus.out_ready && q.size() > 0;
    e = ext(bus.memdatain, bus.ld_mode);
    c = rst || flush;
    @(posedge clk);
    #1;
    if (c) begin
      q.delete();
      eq.delete();
      sticky_m = 0;
    end else begin
      if (pop) begin
        void'(q.pop_front());
        void'(eq.pop_front());
      end
      if (push) begin
        q.push_back(e);
        eq.push_back(perr);
        if (perr) sticky_m = 1;
      end
    end
  endtask
  task automatic drive(bit v, logic [W-1:0] d, logic [1:0] m, bit r);
    bus.mem_valid = v;
    bus.memdatain = d;
    bus.ld_mode = m;
    bus.out_ready = r;
`ifdef MDR_PARITY_EN
    bus.mem_parity = ^d;
`endif
    cyc();
  endtask
  initial begin
    logic [W-1:0] fill [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    logic [W-1:0] xin [4] = '{16'hA5F0, 16'hA5F0, 16'hA5F0, 16'h12F0};
    logic [1:0] xm [4] = '{2'b01, 2'b10, 2'b11, 2'b10};
    logic [W-1:0] xout [4] = '{16'h00F0, 16'hFFF0, 16'h00A5, 16'hFFF0};
    rst = 1;
    flush = 0;
    bus.mem_valid = 0;
    bus.memdatain = '0;
    bus.ld_mode = 2'b00;
    bus.out_ready = 0;
`ifdef MDR_PARITY_EN
    bus.mem_parity = 0;
`endif
    @(posedge clk);
    #1;
    rst = 0;
    for (int i = 0; i < 4; i++) drive(1, fill[i], 2'b00, 0);
    chk("full_count", 32'(bus.count), 32'd4);
    chk("full_ready", 32'(bus.mem_ready), 32'd0);
    drive(1, 16'h5555, 2'b00, 0);
    for (int i = 0; i < 4; i++) begin
      chk("drain_word", 32'(bus.memdataout), 32'(fill[i]));
      drive(0, '0, 2'b00, 1);
    end
    drive(0, '0, 2'b00, 1);
    for (int i = 0; i < 4; i++) drive(1, xin[i], xm[i], 0);
    for (int i = 0; i < 4; i++) begin
      chk("ext_word", 32'(bus.memdataout), 32'(xout[i]));
      drive(0, '0, 2'b00, 1);
    end
    for (int i = 0; i < 10; i++) begin
      drive(1, W'(i), 2'b00, 1);
      chk("stream_word", 32'(bus.memdataout), 32'(i));
    end
    drive(0, '0, 2'b00, 1);
    for (int i = 0; i < 10; i++) drive(1, W'(16'h0100 + i), 2'b00, i % 3 != 0);
    for (int i = 0; i < 6; i++) drive(0, '0, 2'b00, 1);
    for (int i = 0; i < 3; i++) drive(1, W'(16'h0A00 + i), 2'b00, 0);
    flush = 1;
    drive(1, 16'h7777, 2'b00, 0);
    flush = 0;
    chk("flush_count", 32'(bus.count), 32'd0);
    chk("flush_valid", 32'(bus.out_valid), 32'd0);
    drive(0, '0, 2'b00, 0);
    for (int i = 0; i < 3; i++) drive(1, W'(16'h0B00 + i), 2'b00, 0);
    rst = 1;
    drive(1, 16'h7777, 2'b00, 1);
    rst = 0;
    chk("rst_count", 32'(bus.count), 32'd0);
    drive(0, '0, 2'b00, 0);
`ifdef MDR_PARITY_EN
    bus.mem_valid = 1;
    bus.memdatain = 16'h0001;
    bus.ld_mode = 2'b00;
    bus.out_ready = 0;
    bus.mem_parity = 0;
    cyc();
    chk("par_head", 32'(bus.par_err), 32'd1);
    drive(1, 16'h0003, 2'b00, 1);
    drive(0, '0, 2'b00, 1);
    chk("par_sticky_hold", 32'(bus.par_err_sticky), 32'd1);
    flush = 1;
    drive(0, '0, 2'b00, 0);
    flush = 0;
    chk("par_sticky_clr", 32'(bus.par_err_sticky), 32'd0);
`endif
    for (int i = 0; i < 400; i++) begin
      flush = $urandom_range(0, 31) == 0;
      rst = $urandom_range(0, 63) == 0;
      bus.mem_valid = 1'($urandom);
      bus.memdatain = W'($urandom);
      bus.ld_mode = 2'($urandom);
      bus.out_ready = 1'($urandom);
`ifdef MDR_PARITY_EN
      bus.mem_parity = $urandom_range(0, 15) == 0 ? ~^bus.memdatain : ^bus.memdatain;
`endif
      cyc();
    end
    flush = 0;
    rst = 0;
    drive(0, '0, 2'b00, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
